// File: rtl/uart_fifo_bridge.sv
// Host-side byte FIFOs bridging to a UART core: TX FIFO drained by a strobe/ack FSM,
// RX FIFO filled on rising edges of the core's receive strobe, with a saturating overrun count.
module uart_fifo_bridge #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int OVR_W    = 8
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [DATA_W-1:0]         TX_DATA,
    input  logic                      TX_VALID,
    output logic                      TX_READY,
    output logic [DATA_W-1:0]         RX_DATA,
    output logic                      RX_VALID,
    input  logic                      RX_READY,
    output logic [$clog2(TX_DEPTH):0] TX_LEVEL,
    output logic [$clog2(RX_DEPTH):0] RX_LEVEL,
    output logic [OVR_W-1:0]          OVR_CNT,
    input  logic                      OVR_CLR,
    output logic [DATA_W-1:0]         CORE_TX_DATA,
    output logic                      CORE_TX_STB,
    input  logic                      CORE_TX_ACK,
    input  logic [DATA_W-1:0]         CORE_RX_DATA,
    input  logic                      CORE_RX_STB,
    output logic                      CORE_RX_ACK
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_LVL = (TX_AW+1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_LVL = (RX_AW+1)'(RX_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // ---------------- TX path ----------------
    logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
    logic [TX_AW:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_level;
    logic              tx_empty, tx_full, tx_push, tx_pop, tx_bypass, tx_wr_en;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              stb_q, stb_d;

    assign tx_level = tx_wr_q - tx_rd_q;
    assign tx_empty = (tx_level == '0);
    assign tx_full  = (tx_level == TX_FULL_LVL);
    assign TX_READY = RESET_N & ~tx_full;
    assign tx_push  = TX_VALID & TX_READY;
    assign tx_wr_en = tx_push & ~tx_bypass;

    always_comb begin
        state_d   = state_q;
        stb_d     = stb_q;
        tx_data_d = tx_data_q;
        tx_pop    = 1'b0;
        tx_bypass = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                // GAP may launch the next byte itself, so the strobe is low for only that one cycle;
                // an empty FIFO hands the incoming host byte straight to the core.
                state_d = ST_IDLE;
                if (!tx_empty || tx_push) begin
                    state_d = ST_SEND;
                    stb_d   = 1'b1;
                    if (!tx_empty) begin
                        tx_data_d = tx_mem_q[tx_rd_q[TX_AW-1:0]];
                        tx_pop    = 1'b1;
                    end else begin
                        tx_data_d = TX_DATA;
                        tx_bypass = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (CORE_TX_ACK) begin
                    stb_d   = 1'b0;
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                stb_d   = 1'b0;
            end
        endcase
    end

    assign tx_wr_d = tx_wr_q + {{TX_AW{1'b0}}, tx_wr_en};
    assign tx_rd_d = tx_rd_q + {{TX_AW{1'b0}}, tx_pop};

    always_ff @(posedge CLK) begin
        if (tx_wr_en) begin
            tx_mem_q[tx_wr_q[TX_AW-1:0]] <= TX_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            state_q   <= ST_IDLE;
            stb_q     <= 1'b0;
            tx_data_q <= '0;
        end else begin
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            state_q   <= state_d;
            stb_q     <= stb_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign TX_LEVEL     = tx_level;
    assign CORE_TX_STB  = stb_q;
    assign CORE_TX_DATA = tx_data_q;

    // ---------------- RX path ----------------
    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
    logic [RX_AW:0]    rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, rx_level;
    logic              rx_full, rx_edge, rx_pop, rx_push, rx_drop;
    logic              rx_prev_q, rx_ack_q;
    logic [OVR_W-1:0]  ovr_q, ovr_d;

    assign rx_level = rx_wr_q - rx_rd_q;
    assign rx_full  = (rx_level == RX_FULL_LVL);
    assign RX_VALID = (rx_level != '0);
    assign RX_DATA  = rx_mem_q[rx_rd_q[RX_AW-1:0]];

    // A same-cycle host pop frees the slot, so a capture on a full FIFO is only dropped without one.
    assign rx_edge  = CORE_RX_STB & ~rx_prev_q;
    assign rx_pop   = RX_VALID & RX_READY;
    assign rx_push  = rx_edge & (~rx_full | rx_pop);
    assign rx_drop  = rx_edge & rx_full & ~rx_pop;

    assign rx_wr_d = rx_wr_q + {{RX_AW{1'b0}}, rx_push};
    assign rx_rd_d = rx_rd_q + {{RX_AW{1'b0}}, rx_pop};

    always_comb begin
        ovr_d = ovr_q;
        if (OVR_CLR) begin
            ovr_d = '0;
        end else if (rx_drop && (ovr_q != '1)) begin
            ovr_d = ovr_q + OVR_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_q[RX_AW-1:0]] <= CORE_RX_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            rx_prev_q <= 1'b0;
            rx_ack_q  <= 1'b0;
            ovr_q     <= '0;
        end else begin
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
            rx_prev_q <= CORE_RX_STB;
            rx_ack_q  <= rx_edge;
            ovr_q     <= ovr_d;
        end
    end

    assign RX_LEVEL    = rx_level;
    assign OVR_CNT     = ovr_q;
    assign CORE_RX_ACK = rx_ack_q;

endmodule
